// File: rtl/spi_flash_pkg.sv
// Shared definitions for the SPI flash command sequencer: opcode encodings,
// flash instruction bytes and sequencer state encodings.
package spi_flash_pkg;

    localparam logic [1:0] OP_RDID = 2'b00;
    localparam logic [1:0] OP_RDSR = 2'b01;
    localparam logic [1:0] OP_READ = 2'b10;
    localparam logic [1:0] OP_RSVD = 2'b11;

    localparam logic [7:0] INST_RDID = 8'h9F;
    localparam logic [7:0] INST_RDSR = 8'h05;
    localparam logic [7:0] INST_READ = 8'h03;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ERR,
        ST_CS_SETUP,
        ST_SEND_INST,
        ST_SEND_ADDR,
        ST_RECV,
        ST_CS_HOLD,
        ST_CS_IDLE
    } seq_state_e;

    // Instruction byte put on the wire for a (non-reserved) opcode.
    function automatic logic [7:0] inst_for(input logic [1:0] op);
        case (op)
            OP_RDID: return INST_RDID;
            OP_RDSR: return INST_RDSR;
            default: return INST_READ;
        endcase
    endfunction

endpackage

// File: rtl/spi_bit_engine.sv
// Mode-0 SPI byte engine running at clk/2. A load starts (or seamlessly
// continues) an 8-bit transfer: SPICLK low phase then high phase per bit,
// MISO captured on the rising SPICLK edge, MOSI advanced on the falling one.
// One shift register serves both directions: received bits enter at the LSB
// as transmit bits leave at the MSB.
module spi_bit_engine (
    input  logic       clk,
    input  logic       reset,
    input  logic       load_i,
    input  logic [7:0] tx_byte_i,
    input  logic       rx_en_i,
    input  logic       miso_i,
    output logic       sclk_o,
    output logic       mosi_o,
    output logic       byte_done_o,
    output logic [7:0] rx_byte_o
);

    logic       active_q;
    logic       ph_q;
    logic       miso_q;
    logic [2:0] bit_q;
    logic [7:0] sh_q;
    logic [7:0] rx_q;

    // Bit sequencing: load has priority so the next byte follows the last
    // falling edge of the current one without a gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q <= 1'b0;
            ph_q     <= 1'b0;
            miso_q   <= 1'b0;
            bit_q    <= 3'd0;
            sh_q     <= 8'h00;
            rx_q     <= 8'h00;
        end else if (load_i) begin
            active_q <= 1'b1;
            ph_q     <= 1'b0;
            bit_q    <= 3'd0;
            sh_q     <= tx_byte_i;
        end else if (active_q) begin
            if (!ph_q) begin
                ph_q   <= 1'b1;
                miso_q <= miso_i;
                if (bit_q == 3'd7 && rx_en_i) begin
                    rx_q <= {sh_q[6:0], miso_i};
                end
            end else begin
                ph_q  <= 1'b0;
                sh_q  <= {sh_q[6:0], miso_q};
                bit_q <= bit_q + 3'd1;
                if (bit_q == 3'd7) begin
                    active_q <= 1'b0;
                end
            end
        end
    end

    assign sclk_o      = ph_q;
    assign mosi_o      = active_q & sh_q[7];
    assign byte_done_o = active_q & ph_q & (bit_q == 3'd7);
    assign rx_byte_o   = rx_q;

endmodule

// File: rtl/spi_flash_sequencer.sv
// Command-level SPI flash controller: accepts RDID / RDSR / READ, frames the
// transfer with chip_select setup/hold/idle gaps, and returns each received
// byte with a one-cycle strobe.
module spi_flash_sequencer
    import spi_flash_pkg::*;
#(
    parameter int unsigned CS_SETUP = 1,
    parameter int unsigned CS_HOLD  = 1,
    parameter int unsigned CS_IDLE  = 4,
    parameter int unsigned LEN_W    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [23:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic             done,
    output logic             err,
    output logic             busy,
    input  logic             SPIMISO,
    output logic             SPICLK,
    output logic             SPIMOSI,
    output logic             chip_select
);

    seq_state_e       state_q, state_d;
    logic [3:0]       cnt_q, cnt_d;
    logic [LEN_W-1:0] bcnt_q, bcnt_d;
    logic [1:0]       op_q, op_d;
    logic [23:0]      addr_q, addr_d;
    logic [LEN_W-1:0] len_q, len_d;

    logic             eng_load;
    logic [7:0]       eng_tx;
    logic             byte_done;

    spi_bit_engine u_engine (
        .clk         (clk),
        .reset       (reset),
        .load_i      (eng_load),
        .tx_byte_i   (eng_tx),
        .rx_en_i     (state_q == ST_RECV),
        .miso_i      (SPIMISO),
        .sclk_o      (SPICLK),
        .mosi_o      (SPIMOSI),
        .byte_done_o (byte_done),
        .rx_byte_o   (rx_data)
    );

    // State, timers, byte counter and the captured command.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            bcnt_q  <= '0;
            op_q    <= OP_RDID;
            addr_q  <= 24'h0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bcnt_q  <= bcnt_d;
            op_q    <= op_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
        end
    end

    // Next-state logic; byte loads are issued on the byte_done cycle so the
    // serial clock runs continuously from the instruction to the last byte.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bcnt_d   = bcnt_q;
        op_d     = op_q;
        addr_d   = addr_q;
        len_d    = len_q;
        eng_load = 1'b0;
        eng_tx   = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    op_d   = cmd_op;
                    addr_d = cmd_addr;
                    cnt_d  = 4'd0;
                    bcnt_d = '0;
                    if (cmd_op == OP_READ) begin
                        len_d = cmd_len;
                    end else if (cmd_op == OP_RDID) begin
                        len_d = LEN_W'(3);
                    end else begin
                        len_d = LEN_W'(1);
                    end
                    if (cmd_op == OP_RSVD) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d = ST_CS_SETUP;
                    end
                end
            end
            ST_ERR: begin
                state_d = ST_IDLE;
            end
            ST_CS_SETUP: begin
                if (cnt_q == 4'(CS_SETUP - 1)) begin
                    eng_load = 1'b1;
                    eng_tx   = inst_for(op_q);
                    cnt_d    = 4'd0;
                    state_d  = ST_SEND_INST;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_SEND_INST: begin
                if (byte_done) begin
                    eng_load = 1'b1;
                    if (op_q == OP_READ) begin
                        eng_tx  = addr_q[23:16];
                        cnt_d   = 4'd0;
                        state_d = ST_SEND_ADDR;
                    end else begin
                        bcnt_d  = '0;
                        state_d = ST_RECV;
                    end
                end
            end
            ST_SEND_ADDR: begin
                if (byte_done) begin
                    if (cnt_q == 4'd0) begin
                        eng_load = 1'b1;
                        eng_tx   = addr_q[15:8];
                        cnt_d    = 4'd1;
                    end else if (cnt_q == 4'd1) begin
                        eng_load = 1'b1;
                        eng_tx   = addr_q[7:0];
                        cnt_d    = 4'd2;
                    end else if (len_q != '0) begin
                        eng_load = 1'b1;
                        bcnt_d   = '0;
                        state_d  = ST_RECV;
                    end else begin
                        cnt_d   = 4'd0;
                        state_d = ST_CS_HOLD;
                    end
                end
            end
            ST_RECV: begin
                if (byte_done) begin
                    // Compare against len-1 so a full-scale length never wraps.
                    if (bcnt_q == len_q - LEN_W'(1)) begin
                        cnt_d   = 4'd0;
                        state_d = ST_CS_HOLD;
                    end else begin
                        eng_load = 1'b1;
                        bcnt_d   = bcnt_q + LEN_W'(1);
                    end
                end
            end
            ST_CS_HOLD: begin
                if (cnt_q == 4'(CS_HOLD - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = ST_CS_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_CS_IDLE: begin
                if (cnt_q == 4'(CS_IDLE - 1)) begin
                    cnt_d   = 4'd0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign err         = (state_q == ST_ERR);
    assign done        = (state_q == ST_CS_IDLE) && (cnt_q == 4'd0);
    assign rx_valid    = byte_done && (state_q == ST_RECV);
    assign chip_select = !((state_q == ST_CS_SETUP) || (state_q == ST_SEND_INST) ||
                           (state_q == ST_SEND_ADDR) || (state_q == ST_RECV) ||
                           (state_q == ST_CS_HOLD));

endmodule

// File: tb/tb_spi_flash_sequencer.sv
// Directed bench for spi_flash_sequencer with a behavioural SPI flash model.
module tb_spi_flash_sequencer;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [23:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        done;
    logic        err;
    logic        busy;
    logic        SPIMISO;
    logic        SPICLK;
    logic        SPIMOSI;
    logic        chip_select;

    spi_flash_sequencer #(.CS_SETUP(1), .CS_HOLD(1), .CS_IDLE(4), .LEN_W(8)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .rx_data(rx_data), .rx_valid(rx_valid), .done(done), .err(err), .busy(busy),
        .SPIMISO(SPIMISO), .SPICLK(SPICLK), .SPIMOSI(SPIMOSI), .chip_select(chip_select)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Flash model: counts SPICLK rises within a frame, logs MOSI, serves MISO.
    int          rise_n   = 0;
    int          mosi_tot = 0;
    logic [63:0] mosi_sr  = 64'h0;
    int          hdr_bits = 8;
    logic [7:0]  resp [8];
    logic [31:0] rel;

    always @(posedge SPICLK or posedge chip_select) begin
        if (chip_select) begin
            rise_n <= 0;
        end else begin
            rise_n   <= rise_n + 1;
            mosi_tot <= mosi_tot + 1;
            mosi_sr  <= {mosi_sr[62:0], SPIMOSI};
        end
    end

    always_comb begin
        rel = 32'(rise_n - hdr_bits);
        if (rise_n < hdr_bits) SPIMISO = 1'b1;
        else                   SPIMISO = resp[rel[5:3]][3'd7 - rel[2:0]];
    end

    int n_cmp = 0;
    int n_fail = 0;

    int done_at, n_done, err_at, n_err, n_rx, cs_low, last_low;
    int sclk_bad, mosi_bad, ready_at, nbits, wait_n, mosi_base, off;
    logic [7:0] rxb [8];
    logic prev_mosi;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a command and step through its accept edge.
    task automatic issue(input logic [1:0] op, input logic [23:0] addr,
                         input logic [7:0] len, input bit hold);
        cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_valid = 1'b1;
        wait_n = 0;
        while (!cmd_ready && wait_n < 200) begin tick(); wait_n++; end
        mosi_base = mosi_tot;
        tick();
        if (!hold) begin
            cmd_valid = 1'b0; cmd_op = ~op; cmd_addr = ~addr; cmd_len = ~len;
        end
    endtask

    // Observe outputs cycle by cycle (offset 1 = cycle after accept) until ready.
    task automatic monitor(input int budget);
        off = 1; done_at = -1; n_done = 0; err_at = -1; n_err = 0; n_rx = 0;
        cs_low = 0; last_low = -1; sclk_bad = 0; mosi_bad = 0; ready_at = -1;
        prev_mosi = SPIMOSI;
        while (off <= budget) begin
            if (done) begin n_done++; if (done_at < 0) done_at = off; end
            if (err) begin n_err++; if (err_at < 0) err_at = off; end
            if (rx_valid) begin if (n_rx < 8) rxb[n_rx] = rx_data; n_rx++; end
            if (!chip_select) begin cs_low++; last_low = off; end
            if (chip_select && SPICLK) sclk_bad++;
            if (SPICLK && (SPIMOSI !== prev_mosi)) mosi_bad++;
            prev_mosi = SPIMOSI;
            if (cmd_ready) begin ready_at = off; break; end
            tick();
            off++;
        end
        nbits = mosi_tot - mosi_base;
    endtask

    task automatic test_reset();
        reset = 1'b1; cmd_valid = 1'b1; cmd_op = 2'b00; cmd_addr = 24'h0; cmd_len = 8'd0;
        repeat (3) tick();
        n_cmp++; if (chip_select !== 1'b1) begin n_fail++; $display("FAIL reset_cs: got %b want 1", chip_select); end
        n_cmp++; if (SPICLK !== 1'b0) begin n_fail++; $display("FAIL reset_sclk: got %b want 0", SPICLK); end
        n_cmp++; if (SPIMOSI !== 1'b0) begin n_fail++; $display("FAIL reset_mosi: got %b want 0", SPIMOSI); end
        n_cmp++; if ({rx_valid, done, err, busy} !== 4'b0000) begin n_fail++; $display("FAIL reset_strobes: got %b want 0000", {rx_valid, done, err, busy}); end
        n_cmp++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h want 00", rx_data); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        cmd_valid = 1'b0; reset = 1'b0;
        tick();
        n_cmp++; if ({busy, chip_select} !== 2'b01) begin n_fail++; $display("FAIL reset_ignored_req: got busy,cs=%b want 01", {busy, chip_select}); end
    endtask

    task automatic test_rdid();
        hdr_bits = 8; resp[0] = 8'h20; resp[1] = 8'hBA; resp[2] = 8'h18;
        issue(2'b00, 24'h0, 8'd0, 1'b0);
        monitor(300);
        n_cmp++; if (done_at !== 67) begin n_fail++; $display("FAIL rdid_done_at: got %0d want 67", done_at); end
        n_cmp++; if (n_done !== 1) begin n_fail++; $display("FAIL rdid_done_count: got %0d want 1", n_done); end
        n_cmp++; if (cs_low !== 66) begin n_fail++; $display("FAIL rdid_cs_low: got %0d want 66", cs_low); end
        n_cmp++; if (nbits !== 32) begin n_fail++; $display("FAIL rdid_bits: got %0d want 32", nbits); end
        n_cmp++; if (mosi_sr[31:0] !== 32'h9F000000) begin n_fail++; $display("FAIL rdid_mosi: got %h want 9f000000", mosi_sr[31:0]); end
        n_cmp++; if (n_rx !== 3) begin n_fail++; $display("FAIL rdid_rx_count: got %0d want 3", n_rx); end
        n_cmp++; if ({rxb[0], rxb[1], rxb[2]} !== 24'h20BA18) begin n_fail++; $display("FAIL rdid_rx_bytes: got %h want 20ba18", {rxb[0], rxb[1], rxb[2]}); end
        n_cmp++; if (ready_at !== 71) begin n_fail++; $display("FAIL rdid_ready_at: got %0d want 71", ready_at); end
        n_cmp++; if (mosi_bad !== 0) begin n_fail++; $display("FAIL rdid_mosi_on_high: got %0d want 0", mosi_bad); end
        n_cmp++; if (rx_data !== 8'h18) begin n_fail++; $display("FAIL rdid_rx_hold: got %h want 18", rx_data); end
    endtask

    task automatic test_rdsr();
        hdr_bits = 8; resp[0] = 8'h5A;
        issue(2'b01, 24'h0, 8'd9, 1'b0);
        monitor(200);
        n_cmp++; if (done_at !== 35) begin n_fail++; $display("FAIL rdsr_done_at: got %0d want 35", done_at); end
        n_cmp++; if (n_rx !== 1) begin n_fail++; $display("FAIL rdsr_rx_count: got %0d want 1", n_rx); end
        n_cmp++; if (rxb[0] !== 8'h5A) begin n_fail++; $display("FAIL rdsr_rx_byte: got %h want 5a", rxb[0]); end
        n_cmp++; if (mosi_sr[15:0] !== 16'h0500) begin n_fail++; $display("FAIL rdsr_mosi: got %h want 0500", mosi_sr[15:0]); end
    endtask

    task automatic test_read();
        hdr_bits = 32; resp[0] = 8'hDE; resp[1] = 8'hAD; resp[2] = 8'hBE; resp[3] = 8'hEF;
        issue(2'b10, 24'h012345, 8'd4, 1'b0);
        monitor(300);
        n_cmp++; if (done_at !== 131) begin n_fail++; $display("FAIL read_done_at: got %0d want 131", done_at); end
        n_cmp++; if (nbits !== 64) begin n_fail++; $display("FAIL read_bits: got %0d want 64", nbits); end
        n_cmp++; if (mosi_sr !== 64'h03012345_00000000) begin n_fail++; $display("FAIL read_mosi: got %h want 0301234500000000", mosi_sr); end
        n_cmp++; if (n_rx !== 4) begin n_fail++; $display("FAIL read_rx_count: got %0d want 4", n_rx); end
        n_cmp++; if ({rxb[0], rxb[1], rxb[2], rxb[3]} !== 32'hDEADBEEF) begin n_fail++; $display("FAIL read_rx_bytes: got %h want deadbeef", {rxb[0], rxb[1], rxb[2], rxb[3]}); end
        n_cmp++; if (sclk_bad !== 0) begin n_fail++; $display("FAIL read_sclk_cs_high: got %0d want 0", sclk_bad); end
    endtask

    task automatic test_read_len0();
        hdr_bits = 32;
        issue(2'b10, 24'hA5C3F0, 8'd0, 1'b0);
        monitor(200);
        n_cmp++; if (done_at !== 67) begin n_fail++; $display("FAIL len0_done_at: got %0d want 67", done_at); end
        n_cmp++; if (nbits !== 32) begin n_fail++; $display("FAIL len0_bits: got %0d want 32", nbits); end
        n_cmp++; if (mosi_sr[31:0] !== 32'h03A5C3F0) begin n_fail++; $display("FAIL len0_mosi: got %h want 03a5c3f0", mosi_sr[31:0]); end
        n_cmp++; if (n_rx !== 0) begin n_fail++; $display("FAIL len0_rx_count: got %0d want 0", n_rx); end
    endtask

    task automatic test_reserved();
        issue(2'b11, 24'h0, 8'd3, 1'b0);
        monitor(50);
        n_cmp++; if (err_at !== 1) begin n_fail++; $display("FAIL rsvd_err_at: got %0d want 1", err_at); end
        n_cmp++; if (n_err !== 1) begin n_fail++; $display("FAIL rsvd_err_count: got %0d want 1", n_err); end
        n_cmp++; if (ready_at !== 2) begin n_fail++; $display("FAIL rsvd_ready_at: got %0d want 2", ready_at); end
        n_cmp++; if (cs_low !== 0) begin n_fail++; $display("FAIL rsvd_cs_low: got %0d want 0", cs_low); end
        n_cmp++; if (sclk_bad !== 0) begin n_fail++; $display("FAIL rsvd_sclk: got %0d want 0", sclk_bad); end
        n_cmp++; if (n_done !== 0) begin n_fail++; $display("FAIL rsvd_done: got %0d want 0", n_done); end
    endtask

    task automatic test_reset_mid();
        int k;
        int bad_done;
        int bad_rx;
        hdr_bits = 8; resp[0] = 8'h20; resp[1] = 8'hBA; resp[2] = 8'h18;
        issue(2'b00, 24'h0, 8'd0, 1'b0);
        k = 0;
        while ((mosi_tot - mosi_base) < 12 && k < 200) begin tick(); k++; end
        n_cmp++; if ((mosi_tot - mosi_base) !== 12) begin n_fail++; $display("FAIL rstmid_bits: got %0d want 12", mosi_tot - mosi_base); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        n_cmp++; if ({chip_select, SPICLK, busy, SPIMOSI} !== 4'b1000) begin n_fail++; $display("FAIL rstmid_outputs: got cs,sclk,busy,mosi=%b want 1000", {chip_select, SPICLK, busy, SPIMOSI}); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b want 1", cmd_ready); end
        bad_done = 0; bad_rx = 0;
        repeat (80) begin
            if (done) bad_done++;
            if (rx_valid) bad_rx++;
            tick();
        end
        n_cmp++; if (bad_done !== 0) begin n_fail++; $display("FAIL rstmid_no_done: got %0d want 0", bad_done); end
        n_cmp++; if (bad_rx !== 0) begin n_fail++; $display("FAIL rstmid_no_rx: got %0d want 0", bad_rx); end
        issue(2'b00, 24'h0, 8'd0, 1'b0);
        monitor(300);
        n_cmp++; if (done_at !== 67) begin n_fail++; $display("FAIL rstmid_again_done_at: got %0d want 67", done_at); end
        n_cmp++; if ({rxb[0], rxb[1], rxb[2]} !== 24'h20BA18 || n_rx !== 3) begin n_fail++; $display("FAIL rstmid_again_rx: got %h (%0d bytes) want 20ba18 (3)", {rxb[0], rxb[1], rxb[2]}, n_rx); end
    endtask

    task automatic test_back_to_back();
        int r1, l1, d1, n1;
        logic [23:0] b1;
        hdr_bits = 8; resp[0] = 8'hC2; resp[1] = 8'h20; resp[2] = 8'h17;
        issue(2'b00, 24'h0, 8'd0, 1'b1);
        monitor(300);
        r1 = ready_at; l1 = last_low; d1 = done_at; n1 = n_rx; b1 = {rxb[0], rxb[1], rxb[2]};
        issue(2'b00, 24'h0, 8'd0, 1'b0);
        n_cmp++; if (wait_n !== 0) begin n_fail++; $display("FAIL b2b_immediate_accept: got %0d wait want 0", wait_n); end
        monitor(300);
        n_cmp++; if (r1 - d1 !== 4) begin n_fail++; $display("FAIL b2b_ready_after_done: got %0d want 4", r1 - d1); end
        n_cmp++; if (r1 - l1 < 5) begin n_fail++; $display("FAIL b2b_cs_gap: got %0d want >=5", r1 - l1); end
        n_cmp++; if (b1 !== 24'hC22017 || n1 !== 3) begin n_fail++; $display("FAIL b2b_first_rx: got %h (%0d) want c22017 (3)", b1, n1); end
        n_cmp++; if ({rxb[0], rxb[1], rxb[2]} !== 24'hC22017 || n_rx !== 3) begin n_fail++; $display("FAIL b2b_second_rx: got %h (%0d) want c22017 (3)", {rxb[0], rxb[1], rxb[2]}, n_rx); end
        n_cmp++; if (done_at !== 67) begin n_fail++; $display("FAIL b2b_second_done_at: got %0d want 67", done_at); end
    endtask

    task automatic test_read_maxlen();
        hdr_bits = 32;
        resp[0] = 8'h11; resp[1] = 8'h22; resp[2] = 8'h33; resp[3] = 8'h44;
        resp[4] = 8'h55; resp[5] = 8'h66; resp[6] = 8'h77; resp[7] = 8'h88;
        issue(2'b10, 24'hFFFFFF, 8'd255, 1'b0);
        monitor(5000);
        n_cmp++; if (n_rx !== 255) begin n_fail++; $display("FAIL maxlen_rx_count: got %0d want 255", n_rx); end
        n_cmp++; if (done_at !== 4147) begin n_fail++; $display("FAIL maxlen_done_at: got %0d want 4147", done_at); end
        n_cmp++; if (nbits !== 2072) begin n_fail++; $display("FAIL maxlen_bits: got %0d want 2072", nbits); end
        n_cmp++; if (rxb[0] !== 8'h11 || rxb[7] !== 8'h88) begin n_fail++; $display("FAIL maxlen_rx_bytes: got %h..%h want 11..88", rxb[0], rxb[7]); end
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = 24'h0; cmd_len = 8'd0;
        test_reset();
        test_rdid();
        test_rdsr();
        test_read();
        test_read_len0();
        test_reserved();
        test_reset_mid();
        test_back_to_back();
        test_read_maxlen();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "watchdog");
    end

endmodule
